scr1_sp_tcm: RTL and testbench
==============================

SCR1_SP_TCM -- requirements
Module: scr1_sp_tcm

Interface
REQ-001 Parameter SCR1_TCM_SIZE, default 32'h00010000, TCM size in bytes; power of two, 1 KiB to 1 MiB.
REQ-002 Parameter SCR1_TCM_BASE, default 32'h00000000, byte base address; aligned to SCR1_TCM_SIZE.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  in  1  instruction fetch request.
REQ-006 imem_cmd  in  type_scr1_mem_cmd_e  ignored; the imem port is read-only.
REQ-007 imem_addr  in  SCR1_IMEM_AWIDTH  fetch byte address.
REQ-008 imem_req_ack  out  1  fetch accepted this cycle.
REQ-009 imem_rdata  out  SCR1_IMEM_DWIDTH  fetch data.
REQ-010 imem_resp  out  type_scr1_mem_resp_e  fetch response.
REQ-011 dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata  in  1/cmd/width/SCR1_DMEM_AWIDTH/SCR1_DMEM_DWIDTH  data request fields.
REQ-012 dmem_req_ack  out  1  data request accepted this cycle.
REQ-013 dmem_rdata  out  SCR1_DMEM_DWIDTH  load data, right-aligned.
REQ-014 dmem_resp  out  type_scr1_mem_resp_e  data response.

Function
REQ-015 Storage SHALL be one single-port array of SCR1_TCM_SIZE/4 32-bit words with per-byte write enables, performing at most one access per cycle.
REQ-016 Each req_ack SHALL be combinational from the port's req, the other port's req, and the arbiter state; at most one of imem_req_ack/dmem_req_ack SHALL be high per cycle.
REQ-017 A request acked in cycle N SHALL get a resp other than NOTRDY in cycle N+1 only; resp SHALL be NOTRDY in every other cycle.
REQ-018 Back-to-back acks on consecutive cycles SHALL be supported, giving full throughput of 1 access per cycle.
REQ-019 Arbitration SHALL be fixed dmem-over-imem priority, or round-robin per REQ-033.
REQ-020 An address outside [SCR1_TCM_BASE, SCR1_TCM_BASE+SCR1_TCM_SIZE) SHALL be acked, SHALL perform no array access, and SHALL return resp RDY_ER in N+1.
REQ-021 Word index SHALL be (addr - SCR1_TCM_BASE) bits [log2(SIZE)-1:2].
REQ-022 Writes: BYTE SHALL replicate wdata[7:0] with byteen 1<<addr[1:0]; HWORD SHALL replicate wdata[15:0] with byteen 2'b11<<{addr[1],0}; WORD SHALL use byteen 4'b1111.
REQ-023 A write SHALL return RDY_OK in N+1; dmem_rdata is don't-care in that cycle.
REQ-024 For loads, dmem_rdata in N+1 SHALL be the array word >> (8*addr[1:0]), using addr[1:0] registered at cycle N.
REQ-025 imem_rdata in N+1 SHALL be the full addressed word.
REQ-026 A write in cycle N followed by a read of the same word in N+1 SHALL return the new data.
REQ-027 A request held high while not acked SHALL keep its fields stable; the block does not check this.

Reset
REQ-028 While rst_n is low: imem_req_ack=0, dmem_req_ack=0, imem_resp=NOTRDY, dmem_resp=NOTRDY.
REQ-029 Reset SHALL clear the response-pending flags, registered byte offset and round-robin pointer (pointer favours imem first).
REQ-030 A response pending when reset asserts SHALL be dropped; no resp for it SHALL appear after deassertion.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 Acks SHALL be permitted from the first rising edge after rst_n deassertion.

Configuration
REQ-033 With SCR1_TCM_RR_ARB_EN defined, on contention the port not granted last SHALL win, and a pending requester SHALL be acked within 2 cycles.
REQ-034 With SCR1_TCM_RR_ARB_EN undefined, dmem SHALL always win on contention and the round-robin pointer SHALL not exist.

Verification
REQ-035 Word write 0xDEADBEEF to BASE+0x10, then WORD load from BASE+0x10 -> write resp RDY_OK at N+1; load dmem_rdata=0xDEADBEEF at N+3.
REQ-036 BYTE write 0xA5 to BASE+0x13 over 0x00000000, then load from BASE+0x13 -> word=0xA5000000; dmem_rdata[7:0]=0xA5.
REQ-037 imem_req and dmem_req held high for 4 cycles with RR_ARB_EN -> acks I,D,I,D; without RR_ARB_EN -> D,D,D,D.
REQ-038 dmem load from BASE+SCR1_TCM_SIZE -> ack in N; dmem_resp=RDY_ER in N+1; array unchanged.
REQ-039 Fetch acked, rst_n pulsed low before next edge -> imem_resp stays NOTRDY through reset and after release.
REQ-040 Fetches of BASE+0x0, 0x4, 0x8 on consecutive cycles -> three RDY_OK responses on consecutive cycles with matching words.

Source files
------------

// File: rtl/scr1_sp_tcm_if.sv
// Shared memory-bus types and the TCM bus interface (imem fetch port + dmem load/store port).
package scr1_sp_tcm_pkg;
   localparam int SCR1_IMEM_AWIDTH = 32;
   localparam int SCR1_IMEM_DWIDTH = 32;
   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

interface scr1_sp_tcm_if;
   import scr1_sp_tcm_pkg::*;

   logic                        imem_req;
   type_scr1_mem_cmd_e          imem_cmd;
   logic [SCR1_IMEM_AWIDTH-1:0] imem_addr;
   logic                        imem_req_ack;
   logic [SCR1_IMEM_DWIDTH-1:0] imem_rdata;
   type_scr1_mem_resp_e         imem_resp;

   logic                        dmem_req;
   type_scr1_mem_cmd_e          dmem_cmd;
   type_scr1_mem_width_e        dmem_width;
   logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
   logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
   logic                        dmem_req_ack;
   logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
   type_scr1_mem_resp_e         dmem_resp;

   modport master (
      output imem_req, imem_cmd, imem_addr,
      input  imem_req_ack, imem_rdata, imem_resp,
      output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      input  dmem_req_ack, dmem_rdata, dmem_resp
   );

   modport slave (
      input  imem_req, imem_cmd, imem_addr,
      output imem_req_ack, imem_rdata, imem_resp,
      input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      output dmem_req_ack, dmem_rdata, dmem_resp
   );
endinterface

// File: rtl/scr1_sp_tcm.sv
// Single-port tightly-coupled memory shared by imem and dmem, one access per cycle.
// Define SCR1_TCM_RR_ARB_EN for round-robin arbitration; otherwise dmem has fixed priority.
module scr1_sp_tcm
   import scr1_sp_tcm_pkg::*;
#(
   parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
   parameter logic [31:0] SCR1_TCM_BASE = 32'h00000000
) (
   input logic          clk,
   input logic          rst_n,
   scr1_sp_tcm_if.slave tcm
);
   localparam int AW    = $clog2(SCR1_TCM_SIZE);
   localparam int WORDS = int'(SCR1_TCM_SIZE / 4);

   logic          imem_gnt, dmem_gnt;
   logic [31:0]   i_offs, d_offs;
   logic          i_in, d_in;
   logic [AW-3:0] idx;
   logic [3:0]    be;
   logic [31:0]   wdat;
   logic          rd_en, wr_en;
   logic [31:0]   rd_word;
   logic          i_vld_q, i_err_q, d_vld_q, d_err_q;
   logic [1:0]    d_off_q;
   logic [31:0]   mem [WORDS];

   // ---------------- arbitration ----------------
`ifdef SCR1_TCM_RR_ARB_EN
   logic rr_dmem_q;  // 1: dmem wins the next contention

   always_comb begin
      dmem_gnt = rst_n & tcm.dmem_req & (~tcm.imem_req |  rr_dmem_q);
      imem_gnt = rst_n & tcm.imem_req & (~tcm.dmem_req | ~rr_dmem_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rr_dmem_q <= 1'b0;
      else if (imem_gnt) rr_dmem_q <= 1'b1;
      else if (dmem_gnt) rr_dmem_q <= 1'b0;
   end
`else
   always_comb begin
      dmem_gnt = rst_n & tcm.dmem_req;
      imem_gnt = rst_n & tcm.imem_req & ~tcm.dmem_req;
   end
`endif

   assign tcm.imem_req_ack = imem_gnt;
   assign tcm.dmem_req_ack = dmem_gnt;

   // ---------------- address decode and array port mux ----------------
   // Base is size-aligned, so an unsigned offset compare covers both sides of the window.
   assign i_offs = tcm.imem_addr - SCR1_TCM_BASE;
   assign d_offs = tcm.dmem_addr - SCR1_TCM_BASE;
   assign i_in   = (i_offs < SCR1_TCM_SIZE);
   assign d_in   = (d_offs < SCR1_TCM_SIZE);

   always_comb begin
      idx   = '0;
      be    = 4'b0000;
      wdat  = tcm.dmem_wdata;
      rd_en = 1'b0;
      wr_en = 1'b0;
      if (dmem_gnt) begin
         idx = d_offs[AW-1:2];
         if (d_in) begin
            if (tcm.dmem_cmd == SCR1_MEM_CMD_WR) wr_en = 1'b1;
            else                                 rd_en = 1'b1;
         end
         case (tcm.dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
               wdat = {4{tcm.dmem_wdata[7:0]}};
               be   = 4'b0001 << tcm.dmem_addr[1:0];
            end
            SCR1_MEM_WIDTH_HWORD: begin
               wdat = {2{tcm.dmem_wdata[15:0]}};
               be   = 4'b0011 << {tcm.dmem_addr[1], 1'b0};
            end
            default: be = 4'b1111;
         endcase
      end else if (imem_gnt) begin
         idx   = i_offs[AW-1:2];
         rd_en = i_in;
      end
   end

   // ---------------- storage (not reset) ----------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
      if (rd_en) rd_word <= mem[idx];
   end

   // ---------------- response stage ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_vld_q <= 1'b0;
         i_err_q <= 1'b0;
         d_vld_q <= 1'b0;
         d_err_q <= 1'b0;
         d_off_q <= 2'b00;
      end else begin
         i_vld_q <= imem_gnt;
         i_err_q <= imem_gnt & ~i_in;
         d_vld_q <= dmem_gnt;
         d_err_q <= dmem_gnt & ~d_in;
         if (dmem_gnt) d_off_q <= tcm.dmem_addr[1:0];
      end
   end

   assign tcm.imem_resp  = !i_vld_q ? SCR1_MEM_RESP_NOTRDY :
                           i_err_q  ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
   assign tcm.dmem_resp  = !d_vld_q ? SCR1_MEM_RESP_NOTRDY :
                           d_err_q  ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
   assign tcm.imem_rdata = rd_word;
   assign tcm.dmem_rdata = rd_word >> {d_off_q, 3'b000};

endmodule

// File: tb/tb_scr1_sp_tcm.sv
// Bench for scr1_sp_tcm: vector table, directed corner sequences and random traffic vs a byte-level model.
module tb_scr1_sp_tcm;
   import scr1_sp_tcm_pkg::*;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam logic [31:0] SIZE = 32'h0000_1000;
   localparam logic [1:0]  NR = 2'b00, OK = 2'b01, ER = 2'b10;
   localparam int          WIN = 64;  // model tracks the first WIN words

   logic clk, rst_n;
   scr1_sp_tcm_if tif ();

   scr1_sp_tcm #(.SCR1_TCM_SIZE(SIZE), .SCR1_TCM_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .tcm(tif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0, bad = 0;

   logic [31:0] mdl [WIN];
   bit          mvld [WIN];
   bit          pi, pd, ei_chk, ed_chk, imem_turn;
   logic [1:0]  ei_resp, ed_resp;
   logic [31:0] ei_data, ed_data;
   bit          gi_e, gd_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      pi = 0; pd = 0; imem_turn = 1;
   endtask

   // Store as a byte-lane update: n bytes at the n-aligned slot holding the address.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] w,
                                         input logic [1:0] a, input logic [31:0] wd);
      logic [31:0] r;
      int n, b0;
      r  = old;
      n  = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      b0 = (int'(a) / n) * n;
      for (int k = 0; k < n; k++) r[8*(b0+k) +: 8] = wd[8*k +: 8];
      return r;
   endfunction

   task automatic step(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwr, input logic [1:0] dw, input logic [31:0] daddr,
                       input logic [31:0] wd);
      logic [31:0] off;
      int          wi;
      @(posedge clk); #1;
      tif.imem_req   = ireq;
      tif.imem_cmd   = SCR1_MEM_CMD_RD;
      tif.imem_addr  = iaddr;
      tif.dmem_req   = dreq;
      tif.dmem_cmd   = dwr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      tif.dmem_width = type_scr1_mem_width_e'(dw);
      tif.dmem_addr  = daddr;
      tif.dmem_wdata = wd;
      @(negedge clk);
      chk("imem_resp", 32'(tif.imem_resp), 32'(pi ? ei_resp : NR));
      if (pi && ei_chk) chk("imem_rdata", tif.imem_rdata, ei_data);
      chk("dmem_resp", 32'(tif.dmem_resp), 32'(pd ? ed_resp : NR));
      if (pd && ed_chk) chk("dmem_rdata", tif.dmem_rdata, ed_data);
`ifdef SCR1_TCM_RR_ARB_EN
      if (ireq && dreq) begin gi_e = imem_turn; gd_e = !imem_turn; end
      else begin gi_e = ireq; gd_e = dreq; end
`else
      gd_e = dreq;
      gi_e = ireq && !dreq;
`endif
      chk("imem_req_ack", 32'(tif.imem_req_ack), 32'(gi_e));
      chk("dmem_req_ack", 32'(tif.dmem_req_ack), 32'(gd_e));
      if (gi_e) imem_turn = 0;
      else if (gd_e) imem_turn = 1;
      pi = gi_e; pd = gd_e;
      if (gi_e) begin
         off = iaddr - BASE;
         wi = int'(off >> 2);
         ei_resp = (off >= SIZE) ? ER : OK;
         ei_chk  = (off < SIZE) && (wi < WIN) && mvld[wi];
         if (ei_chk) ei_data = mdl[wi];
      end
      if (gd_e) begin
         off = daddr - BASE;
         wi = int'(off >> 2);
         ed_resp = (off >= SIZE) ? ER : OK;
         ed_chk  = 0;
         if (off < SIZE && wi < WIN) begin
            if (dwr) begin
               mdl[wi]  = merge(mdl[wi], dw, daddr[1:0], wd);
               mvld[wi] = mvld[wi] || (dw == 2'd2);
            end else if (mvld[wi]) begin
               ed_chk  = 1;
               ed_data = mdl[wi] >> (8 * daddr[1:0]);
            end
         end
      end
   endtask

   task automatic idle();
      step(0, BASE, 0, 0, 2'd2, BASE, 32'h0);
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  w;
      logic [31:0] off;
      logic [31:0] wd;
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [31:0] msk;
   } vec_t;

   vec_t tbl [20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic        ih, dh, dwr_h;
      logic [31:0] ia_h, da_h, wd_h;
      logic [1:0]  dw_h;
      bit          exp_i [4];

      for (int i = 0; i < WIN; i++) begin mdl[i] = '0; mvld[i] = 0; end
      mdl_reset();
      gi_e = 0; gd_e = 0;

      tbl[0]  = '{1, 2'd2, 32'h00, 32'h12345678, OK, 32'h0,        32'h0};
      tbl[1]  = '{1, 2'd2, 32'h04, 32'h89ABCDEF, OK, 32'h0,        32'h0};
      tbl[2]  = '{1, 2'd2, 32'h08, 32'h0F1E2D3C, OK, 32'h0,        32'h0};
      tbl[3]  = '{1, 2'd2, 32'h10, 32'hDEADBEEF, OK, 32'h0,        32'h0};
      tbl[4]  = '{0, 2'd2, 32'h10, 32'h0,        OK, 32'hDEADBEEF, 32'hFFFFFFFF};
      tbl[5]  = '{1, 2'd2, 32'h10, 32'h00000000, OK, 32'h0,        32'h0};
      tbl[6]  = '{1, 2'd0, 32'h13, 32'h000000A5, OK, 32'h0,        32'h0};
      tbl[7]  = '{0, 2'd2, 32'h10, 32'h0,        OK, 32'hA5000000, 32'hFFFFFFFF};
      tbl[8]  = '{0, 2'd0, 32'h13, 32'h0,        OK, 32'h000000A5, 32'h000000FF};
      tbl[9]  = '{1, 2'd2, 32'h14, 32'h11223344, OK, 32'h0,        32'h0};
      tbl[10] = '{1, 2'd1, 32'h16, 32'h0000BEEF, OK, 32'h0,        32'h0};
      tbl[11] = '{0, 2'd2, 32'h14, 32'h0,        OK, 32'hBEEF3344, 32'hFFFFFFFF};
      tbl[12] = '{0, 2'd1, 32'h16, 32'h0,        OK, 32'h0000BEEF, 32'h0000FFFF};
      tbl[13] = '{1, 2'd0, 32'h15, 32'h000000C3, OK, 32'h0,        32'h0};
      tbl[14] = '{0, 2'd0, 32'h15, 32'h0,        OK, 32'h00BEEFC3, 32'hFFFFFFFF};
      tbl[15] = '{0, 2'd2, SIZE,   32'h0,        ER, 32'h0,        32'h0};
      tbl[16] = '{1, 2'd2, SIZE,   32'hFFFFFFFF, ER, 32'h0,        32'h0};
      tbl[17] = '{0, 2'd2, 32'h00, 32'h0,        OK, 32'h12345678, 32'hFFFFFFFF};
      tbl[18] = '{1, 2'd2, 32'hFFFFFFFC, 32'h55, ER, 32'h0,        32'h0};
      tbl[19] = '{0, 2'd2, 32'h08, 32'h0,        OK, 32'h0F1E2D3C, 32'hFFFFFFFF};

      // Reset state with both requests raised
      rst_n = 0;
      tif.imem_req = 1; tif.imem_cmd = SCR1_MEM_CMD_RD; tif.imem_addr = BASE;
      tif.dmem_req = 1; tif.dmem_cmd = SCR1_MEM_CMD_WR; tif.dmem_width = SCR1_MEM_WIDTH_WORD;
      tif.dmem_addr = BASE; tif.dmem_wdata = 32'h0;
      #3;
      chk("rst_imem_ack",  32'(tif.imem_req_ack), 0);
      chk("rst_dmem_ack",  32'(tif.dmem_req_ack), 0);
      chk("rst_imem_resp", 32'(tif.imem_resp), 32'(NR));
      chk("rst_dmem_resp", 32'(tif.dmem_resp), 32'(NR));
      @(posedge clk); #1;
      chk("rst_edge_dmem_ack", 32'(tif.dmem_req_ack), 0);
      tif.imem_req = 0; tif.dmem_req = 0;
      @(negedge clk); rst_n = 1;

      // Contention for four cycles
`ifdef SCR1_TCM_RR_ARB_EN
      exp_i = '{1, 0, 1, 0};
`else
      exp_i = '{0, 0, 0, 0};
`endif
      for (int c = 0; c < 4; c++) begin
         step(1, BASE, 1, 0, 2'd2, BASE + 32'h10, 32'h0);
         chk("arb_imem_ack", 32'(tif.imem_req_ack), 32'(exp_i[c]));
         chk("arb_dmem_ack", 32'(tif.dmem_req_ack), 32'(!exp_i[c]));
      end
      idle(); idle();

      // Vector table, each access followed by an idle cycle
      for (int v = 0; v < 20; v++) begin
         step(0, BASE, 1, tbl[v].wr, tbl[v].w, BASE + tbl[v].off, tbl[v].wd);
         chk("tbl_ack", 32'(tif.dmem_req_ack), 1);
         idle();
         chk("tbl_resp", 32'(tif.dmem_resp), 32'(tbl[v].resp));
         if (!tbl[v].wr && tbl[v].resp == OK)
            chk("tbl_rdata", tif.dmem_rdata & tbl[v].msk, tbl[v].rd & tbl[v].msk);
      end

      // Write then read of the same word on back-to-back cycles
      step(0, BASE, 1, 1, 2'd2, BASE + 32'h20, 32'hCAFEF00D);
      step(0, BASE, 1, 0, 2'd2, BASE + 32'h20, 32'h0);
      chk("b2b_wr_resp", 32'(tif.dmem_resp), 32'(OK));
      idle();
      chk("b2b_rd_data", tif.dmem_rdata, 32'hCAFEF00D);

      // Three consecutive fetches
      step(1, BASE + 32'h0, 0, 0, 2'd2, BASE, 32'h0);
      step(1, BASE + 32'h4, 0, 0, 2'd2, BASE, 32'h0);
      chk("fetch0_resp", 32'(tif.imem_resp), 32'(OK));
      chk("fetch0_data", tif.imem_rdata, 32'h12345678);
      step(1, BASE + 32'h8, 0, 0, 2'd2, BASE, 32'h0);
      chk("fetch1_resp", 32'(tif.imem_resp), 32'(OK));
      chk("fetch1_data", tif.imem_rdata, 32'h89ABCDEF);
      idle();
      chk("fetch2_resp", 32'(tif.imem_resp), 32'(OK));
      chk("fetch2_data", tif.imem_rdata, 32'h0F1E2D3C);

      // Fetch acked, then reset pulsed before its response edge
      step(1, BASE + 32'h4, 0, 0, 2'd2, BASE, 32'h0);
      chk("rstp_ack", 32'(tif.imem_req_ack), 1);
      rst_n = 0; tif.imem_req = 0;
      #1;
      chk("rstp_resp_a", 32'(tif.imem_resp), 32'(NR));
      @(posedge clk); #1;
      chk("rstp_resp_b", 32'(tif.imem_resp), 32'(NR));
      @(negedge clk); rst_n = 1;
      mdl_reset();
      idle();
      chk("rstp_resp_c", 32'(tif.imem_resp), 32'(NR));
      idle();

      // Random traffic: fill the model window, then mixed requests
      for (int i = 0; i < WIN; i++) step(0, BASE, 1, 1, 2'd2, BASE + 32'(4*i), $urandom);
      ih = 0; dh = 0; ia_h = BASE; da_h = BASE; dwr_h = 0; dw_h = 2'd2; wd_h = 0;
      for (int c = 0; c < 600; c++) begin
         if (!(ih && !gi_e)) begin
            ih = 1'($urandom_range(0, 1));
            ia_h = ($urandom_range(0, 9) == 0) ? BASE + SIZE + 32'(4*$urandom_range(0, 3))
                                               : BASE + 32'(4*$urandom_range(0, WIN-1));
         end
         if (!(dh && !gd_e)) begin
            dh    = 1'($urandom_range(0, 1));
            dwr_h = 1'($urandom_range(0, 1));
            dw_h  = 2'($urandom_range(0, 2));
            wd_h  = $urandom;
            da_h  = BASE + 32'(4*$urandom_range(0, WIN-1));
            if (dw_h == 2'd0) da_h[1:0] = 2'($urandom_range(0, 3));
            if (dw_h == 2'd1) da_h[1]   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
               da_h = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : BASE + SIZE;
         end
         step(ih, ia_h, dh, dwr_h, dw_h, da_h, wd_h);
      end
      idle(); idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
